// File: rtl/delay_seq_pkg.sv
// Shared types and defaults for the delay sequence generator.
package delay_seq_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_HIGH = 3'd1,
        WAIT   = 3'd2,
        B_HIGH = 3'd3,
        GAP    = 3'd4
    } state_t;

endpackage

// File: rtl/delay_seq_cnt.sv
// Loadable down-counter used to time each phase of the sequence.
// The counter holds at zero; the zero flag tells the FSM a phase is on its last cycle.
module delay_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins; otherwise count down and stick at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/delay_seq_gen.sv
// Generates one a-pulse followed by a b-pulse exactly 'delay' cycles after a rises,
// then a one-cycle done pulse. Outputs are registered decodes of the next state.
module delay_seq_gen
    import delay_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] a_len,
    input  logic [CNT_W-1:0] b_len,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done
);

    state_t           state, nxt;
    logic [CNT_W-1:0] dly_q, al_q, bl_q;
    logic [CNT_W-1:0] d_eff, al_raw, a_eff, b_eff;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             a_d, b_d, done_d;

    // Zero lengths mean one cycle; a is clipped so it never overlaps b
    always_comb begin
        d_eff  = (delay == '0) ? CNT_W'(1) : delay;
        al_raw = (a_len == '0) ? CNT_W'(1) : a_len;
        b_eff  = (b_len == '0) ? CNT_W'(1) : b_len;
        a_eff  = (al_raw > d_eff) ? d_eff : al_raw;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Capture the effective fields when a sequence is accepted; ignored while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= '0;
            al_q  <= '0;
            bl_q  <= '0;
        end else if (state == IDLE && start) begin
            dly_q <= d_eff;
            al_q  <= a_eff;
            bl_q  <= b_eff;
        end
    end

    // Next state and counter loads; counter value is "remaining cycles minus one"
    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: if (start) begin
                nxt      = A_HIGH;
                cnt_load = 1'b1;
                cnt_val  = a_eff - 1'b1;
            end
            A_HIGH: if (cnt_zero) begin
                cnt_load = 1'b1;
                if (al_q < dly_q) begin
                    nxt     = WAIT;
                    cnt_val = dly_q - al_q - 1'b1;
                end else begin
                    nxt     = B_HIGH;
                    cnt_val = bl_q - 1'b1;
                end
            end
            WAIT: if (cnt_zero) begin
                nxt      = B_HIGH;
                cnt_load = 1'b1;
                cnt_val  = bl_q - 1'b1;
            end
            B_HIGH: if (cnt_zero) nxt = GAP;
            GAP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Output decode of the next state, registered below so outputs align with state
    always_comb begin
        a_d    = (nxt == A_HIGH);
        b_d    = (nxt == B_HIGH);
        done_d = (nxt == GAP);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= 1'b0;
            b    <= 1'b0;
            done <= 1'b0;
        end else begin
            a    <= a_d;
            b    <= b_d;
            done <= done_d;
        end
    end

    assign busy = (state != IDLE);

    delay_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .value (cnt_val),
        .zero  (cnt_zero)
    );

endmodule
